// File: rtl/adc_i2c_ctrl_if.sv
// Command/response bundle between the ADC sequencer and the I2C byte engine.
interface adc_i2c_ctrl_if;
  logic [4:0] i2c_cmd;          // {NO_ACK, STOP, READ, WRITE, START}
  logic       i2c_cmd_vld;
  logic [7:0] i2c_wr_data;
  logic [7:0] i2c_rd_data;
  logic       i2c_rd_data_vld;
  logic       i2c_rev_ack;      // 1 = slave NACKed the last written byte
  logic       i2c_done;

  modport master (
    output i2c_cmd, i2c_cmd_vld, i2c_wr_data,
    input  i2c_rd_data, i2c_rd_data_vld, i2c_rev_ack, i2c_done
  );

  modport slave (
    input  i2c_cmd, i2c_cmd_vld, i2c_wr_data,
    output i2c_rd_data, i2c_rd_data_vld, i2c_rev_ack, i2c_done
  );
endinterface

// File: rtl/adc_i2c_ctrl.sv
// PCF8591 read sequencer: write address, control byte, re-address for read,
// read a dummy byte then the fresh sample, and publish it with error flags.
module adc_i2c_ctrl #(
  parameter logic [6:0] DEV_ADDR      = 7'h48,
  parameter logic [7:0] CTRL_BASE     = 8'h40,
  parameter int         SAMPLE_PERIOD = 5_000_000,
  parameter int         TIMEOUT       = 100_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 trig,
  input  logic [1:0]           ch_sel,
  adc_i2c_ctrl_if.master       bus,
  output logic [7:0]           adc_data,
  output logic [1:0]           adc_ch,
  output logic                 adc_data_vld,
  output logic                 ack_err,
  output logic                 timeout_err,
  output logic                 busy
);
  localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_CTRL, RD_ADDR, RD_DUMMY, RD_LAST, FIN} state_t;

  state_t         state, nxt;
  logic [TW-1:0]  timer;
  logic [WW-1:0]  wait_cnt;
  logic           pending, nack;
  logic [1:0]     ch_r;
  logic [7:0]     rd_byte;
  logic           timer_hit, req;

  assign timer_hit = en && (timer == TW'(SAMPLE_PERIOD - 1));
  assign req       = trig | timer_hit;

  // Successor in the fixed command sequence
  always_comb begin
    nxt = FIN;
    case (state)
      IDLE:     nxt = WR_ADDR;
      WR_ADDR:  nxt = WR_CTRL;
      WR_CTRL:  nxt = RD_ADDR;
      RD_ADDR:  nxt = RD_DUMMY;
      RD_DUMMY: nxt = RD_LAST;
      default:  nxt = FIN;
    endcase
  end

  // {cmd, wr_data} presented to the engine for each command state
  function automatic logic [12:0] cmd_word(state_t s, logic [1:0] ch);
    case (s)
      WR_ADDR:  return {5'b00011, DEV_ADDR, 1'b0};
      WR_CTRL:  return {5'b01010, CTRL_BASE | {6'd0, ch}};
      RD_ADDR:  return {5'b00011, DEV_ADDR, 1'b1};
      RD_DUMMY: return {5'b00100, 8'h00};
      RD_LAST:  return {5'b11100, 8'h00};
      default:  return 13'd0;
    endcase
  endfunction

  // Sample timer, request latch, sequencer FSM and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      timer            <= '0;
      wait_cnt         <= '0;
      pending          <= 1'b0;
      nack             <= 1'b0;
      ch_r             <= 2'd0;
      rd_byte          <= 8'd0;
      bus.i2c_cmd      <= 5'd0;
      bus.i2c_cmd_vld  <= 1'b0;
      bus.i2c_wr_data  <= 8'd0;
      adc_data         <= 8'd0;
      adc_ch           <= 2'd0;
      adc_data_vld     <= 1'b0;
      ack_err          <= 1'b0;
      timeout_err      <= 1'b0;
      busy             <= 1'b0;
    end else begin
      bus.i2c_cmd_vld <= 1'b0;
      adc_data_vld    <= 1'b0;
      timeout_err     <= 1'b0;

      if (!en || timer_hit) timer <= '0;
      else                  timer <= timer + 1'b1;

      // IDLE consumes the held request; anything arriving later coalesces
      if (state == IDLE) pending <= req;
      else               pending <= pending | req;

      case (state)
        IDLE: if (pending) begin
          state                            <= WR_ADDR;
          ch_r                             <= ch_sel;
          nack                             <= 1'b0;
          busy                             <= 1'b1;
          {bus.i2c_cmd, bus.i2c_wr_data}   <= cmd_word(WR_ADDR, ch_sel);
          bus.i2c_cmd_vld                  <= 1'b1;
          wait_cnt                         <= '0;
        end
        FIN: begin
          adc_data     <= rd_byte;
          adc_ch       <= ch_r;
          ack_err      <= nack;
          adc_data_vld <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          if (state == RD_LAST && bus.i2c_rd_data_vld) rd_byte <= bus.i2c_rd_data;
          // done beats a coincident timeout
          if (bus.i2c_done) begin
            if ((state == WR_ADDR || state == WR_CTRL || state == RD_ADDR) && bus.i2c_rev_ack)
              nack <= 1'b1;
            state <= nxt;
            if (nxt != FIN) begin
              {bus.i2c_cmd, bus.i2c_wr_data} <= cmd_word(nxt, ch_r);
              bus.i2c_cmd_vld                <= 1'b1;
              wait_cnt                       <= '0;
            end
          end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
            state       <= IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adc_i2c_ctrl.sv
// Scoreboard bench: a reference model queues the expected command strobes and
// results per request; monitors pop and compare as the DUT produces them.
module tb_adc_i2c_ctrl;
  localparam int SP = 1000;
  localparam int TO = 200;

  logic       clk = 1'b0, rst = 1'b1, en = 1'b0, trig = 1'b0;
  logic [1:0] ch_sel = 2'd0;
  logic [7:0] adc_data;
  logic [1:0] adc_ch;
  logic       adc_data_vld, ack_err, timeout_err, busy;

  adc_i2c_ctrl_if bus();

  adc_i2c_ctrl #(.DEV_ADDR(7'h48), .CTRL_BASE(8'h40), .SAMPLE_PERIOD(SP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .en(en), .trig(trig), .ch_sel(ch_sel), .bus(bus.master),
    .adc_data(adc_data), .adc_ch(adc_ch), .adc_data_vld(adc_data_vld),
    .ack_err(ack_err), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] cmd; logic [7:0] data; bit chk_data; } strobe_t;
  typedef struct { bit to; logic [7:0] d; logic [1:0] ch; logic ack; } result_t;

  strobe_t exp_str[$];
  result_t exp_res[$];
  int      starts[$];
  int      vectors = 0, miscompares = 0;
  int      cyc = 0, last_strobe_cyc = 0, nstrobes = 0;
  bit      hang = 0;
  int      nack_sel = 0;
  logic [7:0] dummy_b = 8'h11, sample_b = 8'hA5;
  logic [7:0] last_d = 8'h00;
  logic [1:0] last_ch = 2'd0;
  logic       last_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: what one request on channel ch must produce
  task automatic push_txn(input logic [1:0] ch);
    exp_str.push_back('{5'b00011, 8'h90, 1'b1});
    exp_str.push_back('{5'b01010, 8'h40 | {6'd0, ch}, 1'b1});
    if (hang) begin
      exp_res.push_back('{1'b1, last_d, last_ch, last_ack});
      return;
    end
    exp_str.push_back('{5'b00011, 8'h91, 1'b1});
    exp_str.push_back('{5'b00100, 8'h00, 1'b0});
    exp_str.push_back('{5'b11100, 8'h00, 1'b0});
    last_d = sample_b; last_ch = ch; last_ack = (nack_sel != 0);
    exp_res.push_back('{1'b0, last_d, last_ch, last_ack});
  endtask

  task automatic pulse_trig();
    @(negedge clk); trig = 1'b1;
    @(negedge clk); trig = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_res.size() == 0 && exp_str.size() == 0 && !busy) begin ok = 1; break; end
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL %s: still busy after %0d cycles, %0d results outstanding", name, budget, exp_res.size());
      exp_res.delete(); exp_str.delete();
    end
  endtask

  // I2C engine model: random latency, returns bytes, injects NACK/hang,
  // and checks the command stays put and unstrobed until done
  initial begin : engine
    logic [4:0] c; logic [7:0] d; bit ok, aborted;
    bus.i2c_done = 0; bus.i2c_rd_data_vld = 0; bus.i2c_rev_ack = 0; bus.i2c_rd_data = 0;
    forever begin
      @(negedge clk);
      bus.i2c_done = 0; bus.i2c_rd_data_vld = 0; bus.i2c_rev_ack = 0;
      if (rst || !bus.i2c_cmd_vld) continue;
      c = bus.i2c_cmd; d = bus.i2c_wr_data; ok = 1; aborted = 0;
      if (hang && c == 5'b01010) continue;
      repeat ($urandom_range(1, 5)) begin
        @(negedge clk);
        if (rst) aborted = 1;
        else if (bus.i2c_cmd !== c || bus.i2c_wr_data !== d || bus.i2c_cmd_vld !== 1'b0) ok = 0;
      end
      if (aborted || rst) continue;
      check("cmd_stable_until_done", {31'd0, ok}, 32'd1);
      bus.i2c_done    = 1;
      bus.i2c_rev_ack = (nack_sel == 1 && c == 5'b00011 && !d[0]) ||
                        (nack_sel == 2 && c == 5'b01010) ||
                        (nack_sel == 3 && c == 5'b00011 && d[0]);
      if (c[2]) begin
        bus.i2c_rd_data_vld = 1;
        bus.i2c_rd_data     = c[4] ? sample_b : dummy_b;
      end
    end
  end

  // Monitor: command strobes and results against the model queues
  initial begin : monitor
    strobe_t s; result_t r;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (bus.i2c_cmd_vld) begin
        nstrobes++;
        last_strobe_cyc = cyc;
        if (bus.i2c_cmd == 5'b00011 && bus.i2c_wr_data == 8'h90) starts.push_back(cyc);
        if (exp_str.size() == 0) check("unexpected_strobe", {27'd0, bus.i2c_cmd}, 32'd0);
        else begin
          s = exp_str.pop_front();
          check("strobe_cmd", {27'd0, bus.i2c_cmd}, {27'd0, s.cmd});
          if (s.chk_data) check("strobe_wr_data", {24'd0, bus.i2c_wr_data}, {24'd0, s.data});
        end
      end
      if (adc_data_vld || timeout_err) begin
        if (exp_res.size() == 0) check("unexpected_result", {30'd0, adc_data_vld, timeout_err}, 32'd0);
        else begin
          r = exp_res.pop_front();
          check("result_kind", {30'd0, adc_data_vld, timeout_err}, r.to ? 32'd1 : 32'd2);
          check("adc_data", {24'd0, adc_data}, {24'd0, r.d});
          check("adc_ch", {30'd0, adc_ch}, {30'd0, r.ch});
          check("ack_err", {31'd0, ack_err}, {31'd0, r.ack});
          if (r.to) begin
            check("timeout_latency", cyc - last_strobe_cyc, TO);
            check("busy_after_timeout", {31'd0, busy}, 32'd0);
          end
        end
      end
    end
  end

  initial begin : stim
    int n0;
    bit seen;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_outputs", {bus.i2c_cmd, bus.i2c_cmd_vld, bus.i2c_wr_data, adc_data, adc_ch,
                          adc_data_vld, ack_err, timeout_err, busy}, 32'd0);
    rst = 1'b0;

    // Directed read: ch 2, bytes 0x11 then 0xA5, all ACKed
    ch_sel = 2'd2; dummy_b = 8'h11; sample_b = 8'hA5; nack_sel = 0;
    push_txn(2'd2); pulse_trig(); wait_idle("directed_read", 200);

    // NACK on the write address: still completes, flags ack_err
    ch_sel = 2'd1; sample_b = 8'h3C; nack_sel = 1;
    push_txn(2'd1); pulse_trig(); wait_idle("nack_addr", 200);

    // Randomized reads with random NACK placement
    for (int i = 0; i < 6; i++) begin
      ch_sel = 2'($urandom_range(0, 3)); dummy_b = 8'($urandom); sample_b = 8'($urandom);
      nack_sel = $urandom_range(0, 3);
      push_txn(ch_sel); pulse_trig(); wait_idle("random_read", 200);
    end
    nack_sel = 0;

    // Engine never finishes the control byte
    hang = 1; ch_sel = 2'd3;
    push_txn(2'd3); pulse_trig(); wait_idle("timeout", 400);
    hang = 0;

    // Requests during a busy transaction coalesce into one follow-up
    ch_sel = 2'd0; sample_b = 8'h5A;
    push_txn(2'd0); push_txn(2'd0);
    pulse_trig();
    for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
    repeat (3) begin pulse_trig(); @(negedge clk); end
    wait_idle("coalesce", 400);
    repeat (30) @(negedge clk);

    // Auto-sampling timer: one start per SAMPLE_PERIOD
    starts.delete(); sample_b = 8'hC3; ch_sel = 2'd1;
    repeat (3) push_txn(2'd1);
    @(negedge clk); en = 1'b1;
    wait_idle("timer", 4 * SP);
    en = 1'b0;
    check("timer_starts", starts.size(), 3);
    if (starts.size() == 3) begin
      check("timer_period_1", starts[1] - starts[0], SP);
      check("timer_period_2", starts[2] - starts[1], SP);
    end

    // Reset in the middle of RD_DUMMY
    ch_sel = 2'd2; sample_b = 8'h77;
    push_txn(2'd2); pulse_trig();
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.i2c_cmd_vld && bus.i2c_cmd == 5'b00100) begin seen = 1; break; end
    end
    check("reached_rd_dummy", {31'd0, seen}, 32'd1);
    #1 rst = 1'b1;
    exp_str.delete(); exp_res.delete();
    last_d = 8'h00; last_ch = 2'd0; last_ack = 1'b0;
    @(negedge clk);
    check("midtxn_rst_outputs", {bus.i2c_cmd, bus.i2c_cmd_vld, bus.i2c_wr_data, adc_data, adc_ch,
                                 adc_data_vld, ack_err, timeout_err, busy}, 32'd0);
    #1 rst = 1'b0;
    n0 = nstrobes;
    repeat (50) @(negedge clk);
    check("no_strobe_after_rst", nstrobes - n0, 0);

    // Recovery read after reset
    ch_sel = 2'd3; sample_b = 8'h9E;
    push_txn(2'd3); pulse_trig(); wait_idle("post_reset_read", 200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
